unit_mem_arbiter: RTL and testbench
===================================

# unit_mem_arbiter

Round-robin memory arbiter and transaction sequencer that shares one vector/matrix memory port among the accelerator's processing units. It sits between the units' memory request interfaces (request/grant/done handshake) and the memory. It serialises one transaction at a time, forwards the owner's command fields, and returns read data and a completion pulse to the owning unit only. It also rejects illegal op types and enforces a completion timeout.

## Interface
- NUM_UNITS, 4, number of requesting units (owner index width OWN_W = $clog2(NUM_UNITS))
- TIMEOUT_CYCLES, 255, max cycles in WAIT before forced completion (≥1)
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req  in  NUM_UNITS  per-unit memory request level
- op_type  in  NUM_UNITS×4  per-unit op: 4'b0001 load, 4'b0010 store, 4'b0100 compute
- vec_index, mat_row, mat_col  in  NUM_UNITS×4 each  per-unit address fields
- wdata  in  NUM_UNITS×vector_t  per-unit store data
- grant  out  NUM_UNITS  one-hot ownership, held for the whole transaction
- done  out  NUM_UNITS  one-cycle completion pulse to the owner
- rdata  out  vector_t  result data, broadcast, valid in the done cycle
- m_valid  out  1  command valid to memory
- m_op, m_vec_index, m_mat_row, m_mat_col  out  4 each  latched command fields
- m_wdata  out  vector_t  latched store data
- m_ready  in  1  memory accepts command this cycle (m_valid && m_ready)
- m_done  in  1  memory completion pulse
- m_rdata  in  vector_t  memory read data, valid with m_done
- busy  out  1  state != IDLE
- owner  out  OWN_W  current/last owner index
- op_err  out  1  one-cycle pulse: illegal op_type rejected
- timeout_err  out  1  one-cycle pulse: WAIT timed out

## Operation
- Reset values:
  - grant, done, m_valid, busy, op_err, timeout_err = 0.
  - rdata, m_* fields = 0.
  - owner = 0; internal last_owner = NUM_UNITS-1, so unit 0 wins first; timeout counter = 0. State = IDLE.
- States: IDLE, ISSUE, WAIT, RELEASE.
- IDLE:
  - If any req bit is set, select the first set bit scanning from (last_owner+1) mod NUM_UNITS upward with wrap.
  - Set owner, grant[owner]=1, and latch that unit's op_type/indices/wdata into the m_* registers.
  - Legal op: go to ISSUE with m_valid=1.
  - Illegal op (any value other than the three legal codes): no memory access. Pulse op_err and done[owner], set rdata=0, go to RELEASE.
- ISSUE:
  - Hold m_valid and fields stable until m_ready.
  - On m_ready: clear m_valid, clear the timeout counter, go to WAIT.
  - If req[owner] falls before acceptance (unit aborted): clear m_valid and grant, set last_owner=owner, go to IDLE with no done pulse.
- WAIT:
  - The counter increments each cycle.
  - On m_done: rdata<=m_rdata, pulse done[owner], go to RELEASE.
  - When the counter reaches TIMEOUT_CYCLES without m_done: rdata<=0, pulse done[owner] and timeout_err, go to RELEASE.
  - If req[owner] falls during WAIT: the transaction runs to m_done or timeout, rdata is not updated, and done is not pulsed; then go to RELEASE.
- RELEASE:
  - Wait until req[owner]==0.
  - Then clear grant, set last_owner=owner, go to IDLE.
  - grant is never reassigned while the previous owner still requests.
- m_done outside WAIT is ignored. m_ready is ignored when m_valid=0.
- Only one grant bit is ever set; done is only ever set on the grant bit's index.

## Timing
- All outputs are registered; no combinational path from req to grant.
- req sampled at edge N (IDLE) → grant and m_valid high after edge N; earliest accept at edge N+1.
- m_done at edge M → done pulse and rdata valid for the cycle after edge M.
- Minimum back-to-back turnaround: RELEASE→IDLE→next grant is 2 cycles after the owner drops req.
- Timeout: done/timeout_err are asserted exactly TIMEOUT_CYCLES cycles after entering WAIT.
- Asynchronous reset mid-transaction drops all outputs immediately. The memory must discard the outstanding command.

## Test plan
- Single load: req=4'b0100, op_type[2]=0001, vec_index[2]=5, m_ready on the first cycle, m_done after 3 cycles with m_rdata=V → grant=0100, m_vec_index=5, done[2] pulses once with rdata=V, grant clears the cycle after req[2] falls.
- Fairness: all four req held continuously, each unit deasserts req after its done → grants in order 0,1,2,3,0; no unit is granted twice before all others have been served.
- Backpressure: m_ready held low for 6 cycles → m_valid and m_* stable for all 6 cycles, then exactly one accept.
- Illegal op: op_type=4'b1000 on unit 1 → m_valid never rises, op_err and done[1] pulse together, rdata=0.
- Timeout: TIMEOUT_CYCLES=8, no m_done → timeout_err and done pulse 8 cycles after WAIT entry, rdata=0; a late m_done is ignored.
- Abort: req[owner] drops in ISSUE → m_valid withdrawn, no done; rst_n asserted during WAIT → all outputs 0 and unit 0 is granted first after release.

Source files
------------

// File: rtl/unit_mem_arbiter_if.sv
// Request/grant/done bundle between the processing units and the
// shared memory port. slave = arbiter side, master = units + memory.
interface unit_mem_arbiter_if #(
   parameter int NUM_UNITS = 4,
   parameter int VEC_W     = 32
);
   logic [NUM_UNITS-1:0]            req;
   logic [NUM_UNITS-1:0][3:0]       op_type;
   logic [NUM_UNITS-1:0][3:0]       vec_index;
   logic [NUM_UNITS-1:0][3:0]       mat_row;
   logic [NUM_UNITS-1:0][3:0]       mat_col;
   logic [NUM_UNITS-1:0][VEC_W-1:0] wdata;
   logic [NUM_UNITS-1:0]            grant;
   logic [NUM_UNITS-1:0]            done;
   logic [VEC_W-1:0]                rdata;

   logic             m_valid;
   logic [3:0]       m_op;
   logic [3:0]       m_vec_index;
   logic [3:0]       m_mat_row;
   logic [3:0]       m_mat_col;
   logic [VEC_W-1:0] m_wdata;
   logic             m_ready;
   logic             m_done;
   logic [VEC_W-1:0] m_rdata;

   modport slave (
      input  req, op_type, vec_index, mat_row, mat_col, wdata,
      input  m_ready, m_done, m_rdata,
      output grant, done, rdata,
      output m_valid, m_op, m_vec_index, m_mat_row, m_mat_col,
      output m_wdata
   );

   modport master (
      output req, op_type, vec_index, mat_row, mat_col, wdata,
      output m_ready, m_done, m_rdata,
      input  grant, done, rdata,
      input  m_valid, m_op, m_vec_index, m_mat_row, m_mat_col,
      input  m_wdata
   );
endinterface

// File: rtl/unit_mem_arbiter.sv
// Round-robin arbiter/sequencer sharing one memory port among units.
// Ports: clk, rst_n (async low), bus (slave modport: unit req/grant/
// done + memory command/response), busy, owner, op_err, timeout_err.
module unit_mem_arbiter #(
   parameter int NUM_UNITS      = 4,
   parameter int VEC_W          = 32,
   parameter int TIMEOUT_CYCLES = 255,
   localparam int OWN_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1,
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   unit_mem_arbiter_if.slave    bus,
   output logic                 busy,
   output logic [OWN_W-1:0]     owner,
   output logic                 op_err,
   output logic                 timeout_err
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_ISSUE   = 2'd1;
   localparam logic [1:0] S_WAIT    = 2'd2;
   localparam logic [1:0] S_RELEASE = 2'd3;

   logic [1:0]       state;
   logic [OWN_W-1:0] last_owner;
   logic [CNT_W-1:0] cnt;
   logic             drop;

   logic [OWN_W-1:0] sel;
   logic             found;
   logic [3:0]       sel_op;
   logic             legal;
   logic             own_req;
   logic             cnt_hit;
   logic             aborted;

   // First requester after last_owner, wrapping round.
   always_comb begin
      sel   = '0;
      found = 1'b0;
      for (int i = 1; i <= NUM_UNITS; i++) begin
         if (!found &&
             bus.req[(int'(last_owner) + i) % NUM_UNITS]) begin
            found = 1'b1;
            sel   = OWN_W'((int'(last_owner) + i) % NUM_UNITS);
         end
      end
   end

   assign sel_op  = bus.op_type[sel];
   assign legal   = (sel_op == 4'b0001) ||
                    (sel_op == 4'b0010) ||
                    (sel_op == 4'b0100);
   assign own_req = bus.req[owner];
   assign cnt_hit = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
   // A requester that let go at any point in WAIT gets no result.
   assign aborted = drop || !own_req;
   assign busy    = (state != S_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= S_IDLE;
         last_owner      <= OWN_W'(NUM_UNITS - 1);
         owner           <= '0;
         cnt             <= '0;
         drop            <= 1'b0;
         op_err          <= 1'b0;
         timeout_err     <= 1'b0;
         bus.grant       <= '0;
         bus.done        <= '0;
         bus.rdata       <= '0;
         bus.m_valid     <= 1'b0;
         bus.m_op        <= '0;
         bus.m_vec_index <= '0;
         bus.m_mat_row   <= '0;
         bus.m_mat_col   <= '0;
         bus.m_wdata     <= '0;
      end else begin
         bus.done    <= '0;
         op_err      <= 1'b0;
         timeout_err <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (found) begin
                  owner           <= sel;
                  bus.grant       <= NUM_UNITS'(1) << sel;
                  bus.m_op        <= sel_op;
                  bus.m_vec_index <= bus.vec_index[sel];
                  bus.m_mat_row   <= bus.mat_row[sel];
                  bus.m_mat_col   <= bus.mat_col[sel];
                  bus.m_wdata     <= bus.wdata[sel];
                  if (legal) begin
                     bus.m_valid <= 1'b1;
                     state       <= S_ISSUE;
                  end else begin
                     op_err    <= 1'b1;
                     bus.done  <= NUM_UNITS'(1) << sel;
                     bus.rdata <= '0;
                     state     <= S_RELEASE;
                  end
               end
            end
            S_ISSUE: begin
               // An accepted command is committed even if req drops
               // on the same edge.
               if (bus.m_ready) begin
                  bus.m_valid <= 1'b0;
                  cnt         <= '0;
                  drop        <= 1'b0;
                  state       <= S_WAIT;
               end else if (!own_req) begin
                  bus.m_valid <= 1'b0;
                  bus.grant   <= '0;
                  last_owner  <= owner;
                  state       <= S_IDLE;
               end
            end
            S_WAIT: begin
               if (!own_req)
                  drop <= 1'b1;
               if (bus.m_done || cnt_hit) begin
                  if (!aborted) begin
                     bus.done  <= NUM_UNITS'(1) << owner;
                     bus.rdata <= bus.m_done ? bus.m_rdata : '0;
                  end
                  timeout_err <= !bus.m_done;
                  state       <= S_RELEASE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_RELEASE: begin
               if (!own_req) begin
                  bus.grant  <= '0;
                  last_owner <= owner;
                  state      <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_unit_mem_arbiter.sv
// Directed bench for unit_mem_arbiter: load, illegal op, fairness,
// backpressure, timeout, abort in ISSUE and reset during WAIT.
module tb_unit_mem_arbiter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       busy;
   logic [1:0] owner;
   logic       op_err;
   logic       timeout_err;
   int         errors = 0;
   int         checks = 0;

   unit_mem_arbiter_if #(.NUM_UNITS(4), .VEC_W(32)) bus ();

   unit_mem_arbiter #(
      .NUM_UNITS(4),
      .VEC_W(32),
      .TIMEOUT_CYCLES(8)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus),
      .busy(busy),
      .owner(owner),
      .op_err(op_err),
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag,
                      input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      #2;
      rst_n = 1'b0;
      #3;
      rst_n = 1'b1;
   endtask

   initial begin
      bus.req       = '0;
      bus.op_type   = '0;
      bus.vec_index = '0;
      bus.mat_row   = '0;
      bus.mat_col   = '0;
      bus.wdata     = '0;
      bus.m_ready   = 1'b0;
      bus.m_done    = 1'b0;
      bus.m_rdata   = '0;
      tick();
      chk("rst_grant", 64'(bus.grant), 64'h0);
      chk("rst_busy", 64'(busy), 64'h0);
      chk("rst_mvalid", 64'(bus.m_valid), 64'h0);
      chk("rst_owner", 64'(owner), 64'h0);
      chk("rst_rdata", 64'(bus.rdata), 64'h0);
      rst_n = 1'b1;

      // Single load on unit 2
      bus.op_type[2]   = 4'b0001;
      bus.vec_index[2] = 4'd5;
      bus.req          = 4'b0100;
      bus.m_ready      = 1'b1;
      tick();
      chk("ld_grant", 64'(bus.grant), 64'h4);
      chk("ld_owner", 64'(owner), 64'h2);
      chk("ld_mvalid", 64'(bus.m_valid), 64'h1);
      chk("ld_mvec", 64'(bus.m_vec_index), 64'h5);
      chk("ld_mop", 64'(bus.m_op), 64'h1);
      tick();
      bus.m_ready = 1'b0;
      chk("ld_accept", 64'(bus.m_valid), 64'h0);
      chk("ld_busy", 64'(busy), 64'h1);
      tick();
      tick();
      bus.m_done  = 1'b1;
      bus.m_rdata = 32'hcafe0001;
      tick();
      bus.m_done = 1'b0;
      chk("ld_done", 64'(bus.done), 64'h4);
      chk("ld_rdata", 64'(bus.rdata), 64'hcafe0001);
      tick();
      chk("ld_done_once", 64'(bus.done), 64'h0);
      chk("ld_hold", 64'(bus.grant), 64'h4);
      bus.req = '0;
      tick();
      chk("ld_release", 64'(bus.grant), 64'h0);
      chk("ld_idle", 64'(busy), 64'h0);

      // Illegal op on unit 1
      bus.op_type[1] = 4'b1000;
      bus.req        = 4'b0010;
      tick();
      chk("il_grant", 64'(bus.grant), 64'h2);
      chk("il_operr", 64'(op_err), 64'h1);
      chk("il_done", 64'(bus.done), 64'h2);
      chk("il_mvalid", 64'(bus.m_valid), 64'h0);
      chk("il_rdata", 64'(bus.rdata), 64'h0);
      tick();
      chk("il_operr_once", 64'(op_err), 64'h0);
      chk("il_done_once", 64'(bus.done), 64'h0);
      chk("il_mvalid2", 64'(bus.m_valid), 64'h0);
      bus.req = '0;
      tick();
      chk("il_release", 64'(bus.grant), 64'h0);

      // Fairness, unit 0 first after reset
      do_reset();
      bus.op_type = {4'b0001, 4'b0001, 4'b0001, 4'b0001};
      bus.req     = 4'b1111;
      bus.m_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("rr_grant", 64'(bus.grant), 64'(4'b0001 << (i % 4)));
         tick();
         bus.m_done  = 1'b1;
         bus.m_rdata = 32'(100 + i);
         tick();
         bus.m_done = 1'b0;
         chk("rr_done", 64'(bus.done), 64'(4'b0001 << (i % 4)));
         chk("rr_rdata", 64'(bus.rdata), 64'(100 + i));
         bus.req[i % 4] = 1'b0;
         tick();
         chk("rr_release", 64'(bus.grant), 64'h0);
         bus.req[i % 4] = 1'b1;
      end
      bus.req     = '0;
      bus.m_ready = 1'b0;

      // Backpressure on unit 3 store
      bus.op_type[3]   = 4'b0010;
      bus.vec_index[3] = 4'd7;
      bus.mat_row[3]   = 4'd3;
      bus.mat_col[3]   = 4'd9;
      bus.wdata[3]     = 32'h12345678;
      bus.req          = 4'b1000;
      tick();
      chk("bp_grant", 64'(bus.grant), 64'h8);
      for (int c = 0; c < 6; c++) begin
         chk("bp_mvalid", 64'(bus.m_valid), 64'h1);
         chk("bp_fields", 64'({bus.m_op, bus.m_vec_index,
             bus.m_mat_row, bus.m_mat_col, bus.m_wdata}),
             64'h2739_12345678);
         bus.wdata[3] = 32'hdead0000 + 32'(c);
         if (c < 5)
            tick();
      end
      bus.m_ready = 1'b1;
      tick();
      chk("bp_accept", 64'(bus.m_valid), 64'h0);
      tick();
      chk("bp_one_accept", 64'(bus.m_valid), 64'h0);
      bus.m_ready = 1'b0;
      bus.m_done  = 1'b1;
      bus.m_rdata = 32'h0badf00d;
      tick();
      bus.m_done = 1'b0;
      chk("bp_done", 64'(bus.done), 64'h8);
      chk("bp_rdata", 64'(bus.rdata), 64'h0badf00d);
      bus.req = '0;
      tick();
      chk("bp_release", 64'(bus.grant), 64'h0);

      // Timeout on unit 0
      bus.req     = 4'b0001;
      bus.m_ready = 1'b1;
      tick();
      chk("to_grant", 64'(bus.grant), 64'h1);
      tick();
      bus.m_ready = 1'b0;
      for (int k = 1; k < 8; k++) begin
         tick();
         chk("to_early", 64'({timeout_err, bus.done}), 64'h0);
      end
      tick();
      chk("to_err", 64'(timeout_err), 64'h1);
      chk("to_done", 64'(bus.done), 64'h1);
      chk("to_rdata", 64'(bus.rdata), 64'h0);
      bus.m_done  = 1'b1;
      bus.m_rdata = 32'hffffffff;
      tick();
      bus.m_done = 1'b0;
      chk("to_late_done", 64'({timeout_err, bus.done}), 64'h0);
      chk("to_late_rdata", 64'(bus.rdata), 64'h0);
      bus.req = '0;
      tick();
      chk("to_release", 64'(bus.grant), 64'h0);

      // Abort in ISSUE on unit 2
      bus.req = 4'b0100;
      tick();
      chk("ab_grant", 64'(bus.grant), 64'h4);
      chk("ab_mvalid", 64'(bus.m_valid), 64'h1);
      bus.req = '0;
      tick();
      chk("ab_withdraw", 64'({bus.m_valid, bus.grant}), 64'h0);
      chk("ab_nodone", 64'(bus.done), 64'h0);
      chk("ab_idle", 64'(busy), 64'h0);
      tick();
      chk("ab_nodone2", 64'(bus.done), 64'h0);

      // Reset during WAIT on unit 1
      bus.req     = 4'b0010;
      bus.m_ready = 1'b1;
      tick();
      chk("rw_grant", 64'(bus.grant), 64'h2);
      tick();
      bus.m_ready = 1'b0;
      tick();
      chk("rw_busy", 64'(busy), 64'h1);
      rst_n = 1'b0;
      #1;
      chk("rw_outs", 64'({busy, bus.m_valid, bus.grant,
          bus.done, owner}), 64'h0);
      bus.req = 4'b0011;
      #2;
      rst_n = 1'b1;
      tick();
      chk("rw_first", 64'(bus.grant), 64'h1);
      bus.req = '0;
      tick();
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
